// File: rtl/param_tx_serializer.sv
// Double-buffered parallel-to-serial transmitter: a one-word holding register feeds a
// shift register, with run-time word length and bit order sampled per word.
module param_tx_serializer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              ser_en,
    input  logic              msb_first,
    input  logic [CNT_W-1:0]  data_len,
    output logic              ser_data,
    output logic              ser_done,
    output logic              busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);

    state_t             state_q, state_d;
    logic               hold_full_q, hold_full_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   eff_len_q, eff_len_d;
    logic               eff_order_q, eff_order_d;
    logic               ser_data_q, ser_data_d;
    logic               ser_done_q, ser_done_d;
    logic               busy_q, busy_d;

    logic               load;
    logic [CNT_W-1:0]   len_in;

    // Out-of-range lengths fall back to a full word.
    assign len_in = (data_len == '0 || data_len > FULL_LEN) ? FULL_LEN : data_len;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        count_d     = count_q;
        eff_len_d   = eff_len_q;
        eff_order_d = eff_order_q;
        ser_data_d  = ser_data_q;
        ser_done_d  = 1'b0;
        load        = 1'b0;

        if (data_valid && !hold_full_q) begin
            hold_d      = p_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    if (count_q < eff_len_q) begin
                        if (eff_order_q) begin
                            ser_data_d = shift_q[DATA_W-1];
                            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
                        end else begin
                            ser_data_d = shift_q[0];
                            shift_d    = {1'b0, shift_q[DATA_W-1:1]};
                        end
                        count_d = count_q + 1'b1;
                    end else begin
                        ser_done_d = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // MSB-first words are left-aligned so the top bit of the shifter is always next.
        if (load) begin
            shift_d     = msb_first ? (hold_q << (FULL_LEN - len_in)) : hold_q;
            eff_len_d   = len_in;
            eff_order_d = msb_first;
            count_d     = '0;
            hold_full_d = 1'b0;
            state_d     = SHIFT;
        end

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            eff_len_q   <= FULL_LEN;
            eff_order_q <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            eff_len_q   <= eff_len_d;
            eff_order_q <= eff_order_d;
            ser_data_q  <= ser_data_d;
            ser_done_q  <= ser_done_d;
            busy_q      <= busy_d;
        end
    end

    assign data_ready = !hold_full_q;
    assign ser_data   = ser_data_q;
    assign ser_done   = ser_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_param_tx_serializer.sv
// Bench for param_tx_serializer: table of words with expected bit sequences, a
// scoreboard queue of per-tick events, and hand sequences for chaining, stall and reset.
module tb_param_tx_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] p_data;
    logic       data_valid;
    logic       data_ready;
    logic       ser_en;
    logic       msb_first;
    logic [3:0] data_len;
    logic       ser_data;
    logic       ser_done;
    logic       busy;

    param_tx_serializer #(.DATA_W(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .p_data(p_data), .data_valid(data_valid),
        .data_ready(data_ready), .ser_en(ser_en), .msb_first(msb_first),
        .data_len(data_len), .ser_data(ser_data), .ser_done(ser_done), .busy(busy)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic       msb;
        logic [7:0] seq;   // seq[i] is the i-th bit expected on ser_data
        int         n;
    } vec_t;

    typedef struct {
        logic is_done;
        logic b;
    } ev_t;

    ev_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic tick_enable = 1'b0;
    logic tick_now;
    logic chk_done_low = 1'b0;
    ev_t  ev;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Shift tick every 4th cycle while enabled.
    initial begin
        ser_en = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            ser_en = tick_enable && (cyc % 4 == 0);
        end
    end

    // Scoreboard: every tick taken while busy consumes one expected event.
    always @(posedge CLK) begin
        tick_now = ser_en && busy && RST;
        #1;
        if (chk_done_low) begin
            chk_done_low = 1'b0;
            n_vec++;
            if (ser_done !== 1'b0) begin
                n_err++;
                $display("FAIL done_pulse_width: ser_done=%b required 0", ser_done);
            end
        end
        if (tick_now) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tick: busy tick with nothing expected, ser_done=%b ser_data=%b", ser_done, ser_data);
            end else begin
                ev = sb.pop_front();
                if (ev.is_done) begin
                    chk_done_low = 1'b1;
                    if (ser_done !== 1'b1 || busy !== (sb.size() > 0)) begin
                        n_err++;
                        $display("FAIL done_tick: ser_done=%b busy=%b required ser_done=1 busy=%b",
                                 ser_done, busy, sb.size() > 0);
                    end
                end else if (ser_data !== ev.b || ser_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL bit_tick: ser_data=%b ser_done=%b required ser_data=%b ser_done=0",
                             ser_data, ser_done, ev.b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic push_events(input logic [7:0] seq, input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e.is_done = 1'b0;
            e.b       = seq[i];
            sb.push_back(e);
        end
        e.is_done = 1'b1;
        e.b       = 1'b0;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [7:0] d);
        int t;
        @(negedge CLK);
        p_data     = d;
        data_valid = 1'b1;
        t = 0;
        while (data_ready !== 1'b1 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: data_ready=%b required 1", data_ready);
        end
        @(posedge CLK);
        #1;
        data_valid = 1'b0;
        n_vec++;
        if (data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL accept_ready: data_ready=%b required 0 after accept", data_ready);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(sb.size() == 0 && busy === 1'b0) && t < 3000) begin
            @(posedge CLK);
            #2;
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%b pending=%0d required busy=0 pending=0", busy, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge CLK);
    endtask

    task automatic wait_sb_size(input int sz);
        int t;
        t = 0;
        while (sb.size() != sz && t < 3000) begin
            @(posedge CLK);
            #2;
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL progress_timeout: pending=%0d required %0d", sb.size(), sz);
        end
    endtask

    vec_t vecs[8];
    logic held_data;
    logic held_busy;
    int   bad;

    initial begin
        vecs[0] = '{data: 8'hB4, len: 4'd8,  msb: 1'b0, seq: 8'hB4, n: 8};
        vecs[1] = '{data: 8'hB4, len: 4'd8,  msb: 1'b1, seq: 8'h2D, n: 8};
        vecs[2] = '{data: 8'h13, len: 4'd5,  msb: 1'b0, seq: 8'h13, n: 5};
        vecs[3] = '{data: 8'h13, len: 4'd0,  msb: 1'b0, seq: 8'h13, n: 8};
        vecs[4] = '{data: 8'h13, len: 4'd12, msb: 1'b0, seq: 8'h13, n: 8};
        vecs[5] = '{data: 8'hA5, len: 4'd3,  msb: 1'b1, seq: 8'h05, n: 3};
        vecs[6] = '{data: 8'h3C, len: 4'd1,  msb: 1'b0, seq: 8'h00, n: 1};
        vecs[7] = '{data: 8'hF0, len: 4'd7,  msb: 1'b1, seq: 8'h07, n: 7};

        RST        = 1'b0;
        p_data     = '0;
        data_valid = 1'b0;
        msb_first  = 1'b0;
        data_len   = 4'd8;

        #12;
        n_vec++;
        if (ser_data !== 1'b0 || ser_done !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: ser_data=%b ser_done=%b busy=%b data_ready=%b required 0 0 0 1",
                     ser_data, ser_done, busy, data_ready);
        end
        @(negedge CLK);
        RST = 1'b1;
        tick_enable = 1'b1;
        repeat (2) @(posedge CLK);

        // Table-driven words.
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            msb_first = vecs[i].msb;
            data_len  = vecs[i].len;
            push_events(vecs[i].seq, vecs[i].n);
            send_word(vecs[i].data);
            wait_idle();
            $display("vector %0d: data=%h len=%0d msb=%b done", i, vecs[i].data, vecs[i].len, vecs[i].msb);
        end

        // Back-to-back words chained through the holding register.
        @(negedge CLK);
        msb_first = 1'b0;
        data_len  = 4'd8;
        push_events(8'h01, 8);
        send_word(8'h01);
        push_events(8'h80, 8);
        send_word(8'h80);
        begin
            int t;
            t = 0;
            while (ser_done !== 1'b1 && t < 500) begin
                @(posedge CLK);
                #1;
                t++;
            end
            n_vec++;
            if (t >= 500 || busy !== 1'b1 || data_ready !== 1'b1) begin
                n_err++;
                $display("FAIL chain_reload: busy=%b data_ready=%b timeout=%b required busy=1 data_ready=1",
                         busy, data_ready, t >= 500);
            end
        end
        wait_idle();
        $display("chained words 01,80 done");

        // Stall after the 3rd bit, with a mid-word order change.
        push_events(8'hB4, 8);
        send_word(8'hB4);
        wait_sb_size(6);
        tick_enable = 1'b0;
        held_data = ser_data;
        held_busy = busy;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) msb_first = 1'b1;
            if (ser_data !== held_data || busy !== held_busy || ser_done !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0 || held_busy !== 1'b1 || held_data !== 1'b1) begin
            n_err++;
            $display("FAIL stall_freeze: %0d changed cycles, held ser_data=%b busy=%b required 0 changes, 1, 1",
                     bad, held_data, held_busy);
        end
        tick_enable = 1'b1;
        wait_idle();
        msb_first = 1'b0;
        $display("stalled word B4 done");

        // Asynchronous reset mid-word with a second word held.
        push_events(8'hB4, 8);
        send_word(8'hB4);
        wait_sb_size(5);
        send_word(8'h55);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        n_vec++;
        if (ser_data !== 1'b0 || ser_done !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: ser_data=%b ser_done=%b busy=%b data_ready=%b required 0 0 0 1",
                     ser_data, ser_done, busy, data_ready);
        end
        sb.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge CLK);
            #1;
            if (busy !== 1'b0 || ser_done !== 1'b0 || data_ready !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_discard: %0d cycles with activity after reset, required 0", bad);
        end
        $display("reset mid-word done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
